// File: rtl/seq_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_param_pkg
// Brief    : Opcodes, FSM state encodings and instruction field offsets for
//            the parametrised microsequencer.
// Revision : 1.0
// ============================================================================
package seq_param_pkg;

    localparam logic [3:0] c_OP_NO = 4'h0;
    localparam logic [3:0] c_OP_CI = 4'h1;
    localparam logic [3:0] c_OP_CR = 4'h2;
    localparam logic [3:0] c_OP_JI = 4'h3;
    localparam logic [3:0] c_OP_JR = 4'h4;
    localparam logic [3:0] c_OP_JZ = 4'h5;
    localparam logic [3:0] c_OP_WN = 4'h6;
    localparam logic [3:0] c_OP_CL = 4'h7;
    localparam logic [3:0] c_OP_RT = 4'h8;
    localparam logic [3:0] c_OP_LD = 4'h9;
    localparam logic [3:0] c_OP_DJ = 4'hA;

    localparam logic [1:0] c_ST_RESET = 2'd0;
    localparam logic [1:0] c_ST_READY = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_ERROR = 2'd3;

    // Instruction layout, MSB to LSB: code(4) dst(4) cmd(CMD_W) imm(DATA_W)
    function automatic int inst_width(input int cmd_w, input int data_w);
        return 8 + cmd_w + data_w;
    endfunction

    function automatic int cmd_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int dst_lsb(input int cmd_w, input int data_w);
        return cmd_w + data_w;
    endfunction

    function automatic int code_lsb(input int cmd_w, input int data_w);
        return 4 + cmd_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_param_stack.sv
`default_nettype none
// ============================================================================
// Module   : seq_param_stack
// Brief    : Small LIFO return stack; top-of-stack is visible combinationally.
// Revision : 1.0
// ============================================================================
module seq_param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_CNT_W-1:0] r_cnt;

    assign full  = (r_cnt == c_CNT_W'(DEPTH));
    assign empty = (r_cnt == '0);

    // Entry k holds the (k+1)-th pushed value; top is entry r_cnt-1.
    always_comb begin
        dout = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_cnt == c_CNT_W'(k + 1)) begin
                dout = r_mem[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (r_cnt == c_CNT_W'(k)) begin
                    r_mem[k] <= din;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (push && !full) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_param
// Brief    : Parametrised microsequencer with return stack, loop counter and
//            sticky error state.
// Revision : 1.0
// ============================================================================
module seq_param
    import seq_param_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int CMD_W   = 4,
    parameter int IREG_N  = 4,
    parameter int OREG_N  = 8,
    parameter int STACK_D = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [8+CMD_W+DATA_W-1:0] inst,
    input  logic                      inst_en,
    input  logic [IREG_N*DATA_W-1:0]  ireg,
    output logic [ADDR_W-1:0]         next,
    output logic [CMD_W+DATA_W-1:0]   oreg,
    output logic [OREG_N-1:0]         oreg_wen,
    output logic                      waiting,
    output logic                      error
);

    localparam int         c_SRC_W     = $clog2(IREG_N);
    localparam int         c_CMD_LSB   = cmd_lsb(DATA_W);
    localparam int         c_DST_LSB   = dst_lsb(CMD_W, DATA_W);
    localparam int         c_CODE_LSB  = code_lsb(CMD_W, DATA_W);
    localparam logic [4:0] c_OREG_LIM  = 5'(OREG_N);
    localparam logic [4:0] c_IREG_LIM  = 5'(IREG_N);

    logic [1:0]              r_state;
    logic [1:0]              w_state_d;
    logic [ADDR_W-1:0]       r_next;
    logic [ADDR_W-1:0]       w_next_d;
    logic [CMD_W+DATA_W-1:0] r_oreg;
    logic [CMD_W+DATA_W-1:0] w_oreg_d;
    logic [OREG_N-1:0]       r_wen;
    logic [OREG_N-1:0]       w_wen_d;
    logic [DATA_W-1:0]       r_cnt;
    logic [DATA_W-1:0]       w_cnt_d;
    logic [DATA_W-1:0]       w_cnt_dec;
    logic [c_SRC_W-1:0]      r_wsrc;
    logic [c_SRC_W-1:0]      w_wsrc_d;

    logic [3:0]              w_code;
    logic [3:0]              w_dst;
    logic [CMD_W-1:0]        w_cmd;
    logic [DATA_W-1:0]       w_imm;
    logic [c_SRC_W-1:0]      w_src;
    logic [ADDR_W-1:0]       w_tgt;
    logic [DATA_W-1:0]       w_ireg [IREG_N];
    logic [DATA_W-1:0]       w_sel;
    logic [DATA_W-1:0]       w_wsel;
    logic [ADDR_W-1:0]       w_next_inc;
    logic                    w_dst_bad;
    logic                    w_src_bad;
    logic                    w_fault;
    logic                    w_push;
    logic                    w_pop;
    logic [ADDR_W-1:0]       w_top;
    logic                    w_full;
    logic                    w_empty;

    assign w_code     = inst[c_CODE_LSB +: 4];
    assign w_dst      = inst[c_DST_LSB +: 4];
    assign w_cmd      = inst[c_CMD_LSB +: CMD_W];
    assign w_imm      = inst[DATA_W-1:0];
    assign w_src      = w_imm[c_SRC_W-1:0];
    assign w_tgt      = w_imm[ADDR_W-1:0];
    assign w_next_inc = r_next + ADDR_W'(1);
    assign w_cnt_dec  = (r_cnt == '0) ? '0 : r_cnt - DATA_W'(1);
    assign w_dst_bad  = ({1'b0, w_dst} >= c_OREG_LIM);
    assign w_src_bad  = (5'(w_src) >= c_IREG_LIM);

    generate
        for (genvar k = 0; k < IREG_N; k++) begin : g_ireg
            assign w_ireg[k] = ireg[k*DATA_W +: DATA_W];
        end
    endgenerate

    // Out-of-range selects read as zero; those instructions fault anyway.
    always_comb begin
        w_sel  = '0;
        w_wsel = '0;
        for (int k = 0; k < IREG_N; k++) begin
            if (w_src == c_SRC_W'(k)) begin
                w_sel = w_ireg[k];
            end
            if (r_wsrc == c_SRC_W'(k)) begin
                w_wsel = w_ireg[k];
            end
        end
    end

    always_comb begin
        w_fault = 1'b0;
        case (w_code)
            c_OP_NO, c_OP_JI, c_OP_LD, c_OP_DJ: w_fault = 1'b0;
            c_OP_CI:                            w_fault = w_dst_bad;
            c_OP_CR:                            w_fault = w_dst_bad | w_src_bad;
            c_OP_JR, c_OP_JZ, c_OP_WN:          w_fault = w_src_bad;
            c_OP_CL:                            w_fault = w_full;
            c_OP_RT:                            w_fault = w_empty;
            default:                            w_fault = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_RESET;
            r_next  <= '0;
            r_oreg  <= '0;
            r_wen   <= '0;
            r_cnt   <= '0;
            r_wsrc  <= '0;
        end else begin
            r_state <= w_state_d;
            r_next  <= w_next_d;
            r_oreg  <= w_oreg_d;
            r_wen   <= w_wen_d;
            r_cnt   <= w_cnt_d;
            r_wsrc  <= w_wsrc_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            c_ST_RESET: w_state_d = c_ST_READY;
            c_ST_READY: begin
                if (inst_en) begin
                    if (w_fault) begin
                        w_state_d = c_ST_ERROR;
                    end else if (w_code == c_OP_WN && w_sel == '0) begin
                        w_state_d = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (inst_en && w_wsel != '0) begin
                    w_state_d = c_ST_READY;
                end
            end
            default: w_state_d = c_ST_ERROR;
        endcase
    end

    always_comb begin
        w_next_d = r_next;
        w_oreg_d = '0;
        w_wen_d  = '0;
        w_cnt_d  = r_cnt;
        w_wsrc_d = r_wsrc;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            c_ST_RESET: begin
                w_next_d = '0;
                w_cnt_d  = '0;
            end
            c_ST_READY: begin
                if (inst_en && w_fault) begin
                    w_next_d = '0;
                end else if (inst_en) begin
                    case (w_code)
                        c_OP_CI: begin
                            w_oreg_d = {w_cmd, w_imm};
                            w_wen_d  = OREG_N'(1) << w_dst;
                            w_next_d = w_next_inc;
                        end
                        c_OP_CR: begin
                            w_oreg_d = {w_cmd, w_sel};
                            w_wen_d  = OREG_N'(1) << w_dst;
                            w_next_d = w_next_inc;
                        end
                        c_OP_JI: w_next_d = w_tgt;
                        c_OP_JR: w_next_d = w_sel[ADDR_W-1:0];
                        c_OP_JZ: w_next_d = (w_sel == '0) ? w_tgt : w_next_inc;
                        c_OP_WN: begin
                            if (w_sel != '0) begin
                                w_next_d = w_next_inc;
                            end else begin
                                w_wsrc_d = w_src;
                            end
                        end
                        c_OP_CL: begin
                            w_push   = 1'b1;
                            w_next_d = w_tgt;
                        end
                        c_OP_RT: begin
                            w_pop    = 1'b1;
                            w_next_d = w_top;
                        end
                        c_OP_LD: begin
                            w_cnt_d  = w_imm;
                            w_next_d = w_next_inc;
                        end
                        c_OP_DJ: begin
                            w_cnt_d  = w_cnt_dec;
                            w_next_d = (w_cnt_dec != '0) ? w_tgt : w_next_inc;
                        end
                        default: w_next_d = w_next_inc;
                    endcase
                end
            end
            c_ST_WAIT: begin
                if (inst_en && w_wsel != '0) begin
                    w_next_d = w_next_inc;
                end
            end
            default: w_next_d = '0;
        endcase
    end

    seq_param_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_D)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_next_inc),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    assign next     = r_next;
    assign oreg     = r_oreg;
    assign oreg_wen = r_wen;
    assign waiting  = (r_state == c_ST_WAIT);
    assign error    = (r_state == c_ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_param
// Brief    : Directed self-checking bench for the seq_param microsequencer.
// Revision : 1.0
// ============================================================================
module tb_seq_param;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] inst = '0;
    logic        inst_en = 1'b0;
    logic [31:0] ireg = '0;
    logic [7:0]  next;
    logic [11:0] oreg;
    logic [7:0]  oreg_wen;
    logic        waiting;
    logic        error;

    int checks = 0;
    int errors = 0;

    seq_param #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .CMD_W   (4),
        .IREG_N  (4),
        .OREG_N  (8),
        .STACK_D (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .inst     (inst),
        .inst_en  (inst_en),
        .ireg     (ireg),
        .next     (next),
        .oreg     (oreg),
        .oreg_wen (oreg_wen),
        .waiting  (waiting),
        .error    (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] code, input logic [3:0] dst,
                         input logic [3:0] cmd, input logic [7:0] imm);
        inst    = {code, dst, cmd, imm};
        inst_en = 1'b1;
        cyc();
        inst_en = 1'b0;
    endtask

    task automatic do_reset();
        inst_en = 1'b0;
        reset   = 1'b1;
        cyc();
        reset   = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        cyc();
        check("rst_next", 32'(next), 32'h0);
        check("rst_oreg", 32'(oreg), 32'h0);
        check("rst_wen", 32'(oreg_wen), 32'h0);
        check("rst_wait", 32'(waiting), 32'h0);
        check("rst_err", 32'(error), 32'h0);
        reset = 1'b0;
        cyc();
        check("ready_next", 32'(next), 32'h0);

        // Command writes
        issue(4'h1, 4'd3, 4'hA, 8'h5C);
        check("ci_oreg", 32'(oreg), 32'hA5C);
        check("ci_wen", 32'(oreg_wen), 32'h08);
        check("ci_next", 32'(next), 32'h01);
        issue(4'h0, 4'd0, 4'h0, 8'h00);
        check("no_wen", 32'(oreg_wen), 32'h00);
        check("no_oreg", 32'(oreg), 32'h000);
        check("no_next", 32'(next), 32'h02);

        // Call / return
        issue(4'h3, 4'd0, 4'h0, 8'h05);
        check("ji_next", 32'(next), 32'h05);
        issue(4'h7, 4'd0, 4'h0, 8'h40);
        check("cl_next", 32'(next), 32'h40);
        issue(4'h8, 4'd0, 4'h0, 8'h00);
        check("rt_next", 32'(next), 32'h06);

        // Loop counter
        issue(4'h3, 4'd0, 4'h0, 8'h10);
        issue(4'h9, 4'd0, 4'h0, 8'h03);
        check("ld_next", 32'(next), 32'h11);
        issue(4'hA, 4'd0, 4'h0, 8'h11);
        check("dj1_next", 32'(next), 32'h11);
        issue(4'hA, 4'd0, 4'h0, 8'h11);
        check("dj2_next", 32'(next), 32'h11);
        issue(4'hA, 4'd0, 4'h0, 8'h11);
        check("dj3_next", 32'(next), 32'h12);
        issue(4'hA, 4'd0, 4'h0, 8'h11);
        check("dj_cnt0_next", 32'(next), 32'h13);

        // Register-sourced ops
        ireg[15:8] = 8'h3C;
        issue(4'h2, 4'd0, 4'h5, 8'h01);
        check("cr_oreg", 32'(oreg), 32'h53C);
        check("cr_wen", 32'(oreg_wen), 32'h01);
        check("cr_next", 32'(next), 32'h14);
        issue(4'h4, 4'd0, 4'h0, 8'h01);
        check("jr_next", 32'(next), 32'h3C);
        issue(4'h5, 4'd0, 4'h0, 8'h22);
        check("jz_taken", 32'(next), 32'h22);
        issue(4'h5, 4'd0, 4'h0, 8'h51);
        check("jz_fall", 32'(next), 32'h23);

        // Wait on ireg2
        issue(4'h6, 4'd0, 4'h0, 8'h02);
        check("wn_wait", 32'(waiting), 32'h1);
        check("wn_next", 32'(next), 32'h23);
        for (int i = 0; i < 10; i++) begin
            if (i < 5) issue(4'h6, 4'd0, 4'h0, 8'h02);
            else cyc();
            check("wn_hold_wait", 32'(waiting), 32'h1);
            check("wn_hold_next", 32'(next), 32'h23);
        end
        ireg[23:16] = 8'h01;
        cyc();
        check("wn_noen_wait", 32'(waiting), 32'h1);
        check("wn_noen_next", 32'(next), 32'h23);
        issue(4'h0, 4'd0, 4'h0, 8'h00);
        check("wn_exit_wait", 32'(waiting), 32'h0);
        check("wn_exit_next", 32'(next), 32'h24);
        issue(4'h6, 4'd0, 4'h0, 8'h01);
        check("wn_pass_wait", 32'(waiting), 32'h0);
        check("wn_pass_next", 32'(next), 32'h25);

        // Address wrap
        issue(4'h3, 4'd0, 4'h0, 8'hFF);
        issue(4'h0, 4'd0, 4'h0, 8'h00);
        check("wrap_no", 32'(next), 32'h00);
        issue(4'h3, 4'd0, 4'h0, 8'hFF);
        issue(4'h7, 4'd0, 4'h0, 8'h30);
        check("wrap_cl", 32'(next), 32'h30);
        issue(4'h8, 4'd0, 4'h0, 8'h00);
        check("wrap_rt", 32'(next), 32'h00);

        // Stack overflow
        for (int i = 1; i <= 4; i++) begin
            issue(4'h7, 4'd0, 4'h0, 8'(i * 16));
            check("nest_next", 32'(next), 32'(i * 16));
        end
        issue(4'h7, 4'd0, 4'h0, 8'h50);
        check("ovf_err", 32'(error), 32'h1);
        check("ovf_next", 32'(next), 32'h0);
        for (int i = 0; i < 5; i++) begin
            issue(4'h1, 4'd1, 4'h1, 8'h01);
            check("err_sticky", 32'(error), 32'h1);
            check("err_next", 32'(next), 32'h0);
            check("err_wen", 32'(oreg_wen), 32'h0);
        end
        reset = 1'b1;
        cyc();
        check("err_rst_err", 32'(error), 32'h0);
        check("err_rst_next", 32'(next), 32'h0);
        reset = 1'b0;
        cyc();
        check("err_rdy_err", 32'(error), 32'h0);
        issue(4'h8, 4'd0, 4'h0, 8'h00);
        check("rt_empty_err", 32'(error), 32'h1);
        check("rt_empty_next", 32'(next), 32'h0);

        // Illegal opcode
        do_reset();
        issue(4'h3, 4'd0, 4'h0, 8'h07);
        check("pre_ill_next", 32'(next), 32'h07);
        issue(4'hC, 4'd0, 4'h0, 8'h00);
        check("ill_err", 32'(error), 32'h1);
        check("ill_next", 32'(next), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("ill_hold", 32'(error), 32'h1);
        end
        reset = 1'b1;
        cyc();
        check("ill_rst_err", 32'(error), 32'h0);
        check("ill_rst_next", 32'(next), 32'h0);
        reset = 1'b0;
        cyc();
        check("ill_rdy_err", 32'(error), 32'h0);
        check("ill_rdy_next", 32'(next), 32'h0);
        issue(4'h0, 4'd0, 4'h0, 8'h00);
        check("ill_after_no", 32'(next), 32'h01);

        // Bad destination
        issue(4'h2, 4'd9, 4'h0, 8'h01);
        check("dst_err", 32'(error), 32'h1);
        check("dst_wen", 32'(oreg_wen), 32'h0);

        // Reset during wait
        do_reset();
        ireg[23:16] = 8'h00;
        issue(4'h6, 4'd0, 4'h0, 8'h02);
        check("wn2_wait", 32'(waiting), 32'h1);
        reset = 1'b1;
        cyc();
        check("wn_rst_wait", 32'(waiting), 32'h0);
        check("wn_rst_next", 32'(next), 32'h0);
        reset = 1'b0;
        cyc();
        issue(4'h0, 4'd0, 4'h0, 8'h00);
        check("wn_rst_after", 32'(next), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_param.md
Name: seq_param

Overview:
- Parametrised second-generation microsequencer.
- Fetches instructions by address from an external program store. Drives one-hot writes of {cmd,data} words to OREG_N output registers, and branches on values from IREG_N input registers.
- Keeps the existing NO/CI/CR/JI/JR/JZ/WN opcode semantics, adding subroutine call/return (hardware return stack), a loop counter with decrement-and-branch, and explicit error reporting.
- Sits between the program ROM and the peripheral command registers.

Parameters:
- ADDR_W, 8, program address width; must satisfy ADDR_W <= DATA_W.
- DATA_W, 8, data/immediate width.
- CMD_W, 4, command-nibble width of the output word.
- IREG_N, 4, number of input registers (2..16).
- OREG_N, 8, number of output registers (1..16).
- STACK_D, 4, return-stack depth (>=1).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst  in  8+CMD_W+DATA_W  instruction at address next: [top 4]=code, [next 4]=dst, [next CMD_W]=cmd, [DATA_W-1:0]=imm.
- inst_en  in  1  inst valid this cycle.
- ireg  in  IREG_N*DATA_W  flat input registers; ireg k = bits [k*DATA_W +: DATA_W].
- next  out  ADDR_W  current program address (registered).
- oreg  out  CMD_W+DATA_W  output word (registered).
- oreg_wen  out  OREG_N  one-hot write enable (registered), one cycle wide.
- waiting  out  1  high while in WaitNonZero.
- error  out  1  high while in Error.

Behaviour:
- Reset:
  - reset is sampled on the clock edge; when sampled high, the next edge is Reset state.
  - Outputs in Reset: next=0, oreg=0, oreg_wen=0, waiting=0, error=0, stack empty, loop counter=0.
  - Reset always takes one cycle, then moves to Ready.
  - Reset overrides every state, including mid-WN and Error.
- Field decode:
  - src = imm[clog2(IREG_N)-1:0]; sel = ireg[src].
  - tgt = imm[ADDR_W-1:0].
  - Address arithmetic is modulo 2^ADDR_W (0xFF+1 -> 0x00).
- Output timing: oreg/oreg_wen are updated at the edge that accepts the instruction, so they are visible in the following cycle. Every non-write cycle drives 0 on both.
- Ready state, inst_en=0: hold next; oreg_wen=0.
- Ready state, inst_en=1, by code:
  - 0 NO: next+1.
  - 1 CI: oreg={cmd,imm}; oreg_wen=1<<dst; next+1.
  - 2 CR: oreg={cmd,sel}; oreg_wen=1<<dst; next+1.
  - 3 JI: next=tgt.
  - 4 JR: next=sel[ADDR_W-1:0].
  - 5 JZ: next = (sel==0) ? tgt : next+1.
  - 6 WN: if sel!=0, next+1. Otherwise latch src, hold next, go to WaitNonZero.
  - 7 CL: push next+1 (wrapped) onto the stack; next=tgt.
  - 8 RT: pop the stack into next.
  - 9 LD: loop counter = imm; next+1.
  - A DJ: cnt_n = (cnt==0) ? 0 : cnt-1; cnt = cnt_n; next = (cnt_n!=0) ? tgt : next+1.
- Error conditions, evaluated in Ready when inst_en=1:
  - code B..F;
  - CR/CI with dst >= OREG_N;
  - CR/JR/JZ/WN with src >= IREG_N;
  - CL with stack full (STACK_D entries);
  - RT with stack empty.
- Error state: sticky until reset. Outputs next=0, oreg_wen=0, error=1. The faulting instruction has no side effects (no write, no push/pop, no counter change).
- WaitNonZero state:
  - waiting=1; next held; oreg_wen=0.
  - Exits to Ready with next+1 on the first cycle where inst_en=1 and ireg[latched src]!=0.
  - inst_en=0 keeps waiting regardless of ireg.
- Stack: LIFO of ADDR_W-bit entries. At most one push or pop per cycle; they never coincide.

Decomposition:
- Package seq_param_pkg holds:
  - opcode constants (NO..DJ);
  - 2-bit state encodings (Reset=0, Ready=1, WaitNonZero=2, Error=3);
  - field-offset functions of CMD_W/DATA_W.
- Sub-module seq_param_stack (params WIDTH, DEPTH):
  - ports clock, reset, push, pop, din, dout, full, empty;
  - synchronous; dout shows the top-of-stack combinationally.
- The top level holds the FSM, the loop counter, decode and output registers.

Test Plan:
- CI write: reset, then inst code=1 dst=3 cmd=0xA imm=0x5C with inst_en -> next cycle oreg=0xA5C, oreg_wen=0x08, next=1; following NO -> oreg_wen=0x00.
- Call/return:
  - CL tgt=0x40 at next=0x05 -> next=0x40; RT -> next=0x06.
  - Five nested CL with STACK_D=4 -> 5th gives error=1, next=0.
  - RT on empty stack -> error=1.
- Loop: LD imm=3 at 0x10, DJ tgt=0x11 at 0x11 -> next sequence 0x11,0x11,0x11,0x12; counter ends at 0.
- WN wait:
  - WN src=2 with ireg_2=0 -> waiting=1, next held for 10 cycles.
  - ireg_2=0x01 with inst_en=0 -> still waiting.
  - inst_en=1 -> next+1, waiting=0.
- Errors and reset:
  - code=0xC -> error=1, next=0, held for 5 cycles; reset pulse -> Reset cycle, then Ready with error=0, next=0.
  - Reset asserted mid-WaitNonZero -> waiting=0 after the edge.
- Boundaries:
  - NO at next=0xFF -> next=0x00.
  - CL at 0xFF pushes 0x00.
  - CR dst=9 with OREG_N=8 -> error, oreg_wen stays 0.
